inv_key_stream: RTL
===================

Name: inv_key_stream

Overview:
- Upstream key-feed stage for the AES-128 decryption datapath.
- Expands a loaded 128-bit cipher key into round keys 0..10 and stores them in an internal register file.
- Streams the round keys in reverse order (10 down to 0), one per request, to the iterative inverse-round datapath through its key_in input.
- Sits beside the state register/controller that sequences the inverse rounds.

Parameters:
NR, 10, number of AES rounds; only 10 (AES-128) is supported, and 11 round keys are stored.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_load  input  1  one-cycle pulse; sample cipher_key and start expansion
cipher_key  input  128  AES-128 cipher key, bit 127 = first key byte MSB
rk_start  input  1  pulse; begin a stream at round key NR
rk_next  input  1  pulse; advance the stream to the next lower round key
key_ready  output  1  expansion complete, key stream available
busy  output  1  expansion in progress
round_key  output  128  current round key, registered
rk_valid  output  1  round_key is valid
rk_index  output  4  index (0..10) of round_key
last_key  output  1  round_key is round key 0 (final AddRoundKey)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - key_ready, busy, rk_valid and last_key = 0; round_key = 0; rk_index = 0.
  - rcon = 8'h01; register file cleared.
- IDLE: all outputs held at their reset values.
  - key_load samples cipher_key into rk[0]; cnt=1; rcon=01; goes to EXPAND.
- EXPAND: busy=1, key_ready=0, rk_valid=0.
  - Each cycle: rk[cnt] = f(rk[cnt-1], rcon).
  - f is the FIPS-197 schedule: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - Word w0 = bits 127:96.
  - rcon is updated by xtime: shift left 1, XOR 8'h1b if bit 7 was set. Sequence 01,02,04,08,10,20,40,80,1b,36.
  - cnt==NR: go to READY.
  - Expansion takes exactly 10 cycles: key_load sampled at edge E0 gives key_ready=1 after edge E10.
- READY: key_ready=1, busy=0, rk_valid=0.
  - rk_start: ptr=NR; round_key<=rk[NR]; rk_index<=10; rk_valid<=1; goes to STREAM.
  - rk_next is ignored in READY.
- STREAM: key_ready=1, rk_valid=1.
  - rk_next with ptr>0: ptr-1; round_key/rk_index are updated on that edge, so the new key is valid the next cycle.
  - rk_next with ptr==0: rk_valid<=0, last_key<=0; returns to READY. The stored keys are retained, so rk_start may replay the stream.
  - last_key = rk_valid && ptr==0, registered together with round_key.
- Priorities, highest first: key_load > rk_start > rk_next.
  - key_load in any state, including mid-EXPAND or mid-STREAM, restarts expansion. rk_valid and key_ready drop on that edge.
  - rk_start and rk_next together in STREAM: restart at key 10.
  - rk_start in IDLE or EXPAND: ignored.
- round_key holds its value while no request arrives. The inverse-round datapath may use it combinationally for many cycles.
- No wrap-around: the index never goes below 0 or above 10.

Decomposition:
- Shared package aes_pkg:
  - constants AES_NR=10, AES_NK=4, BLOCK_W=128;
  - rcon table or xtime function;
  - state typedef {IDLE, EXPAND, READY, STREAM}.
- Sub-module aes_sbox: forward S-box, 8-bit combinational lookup, instantiated 4 times for SubWord.
- The register file and the FSM stay in the top module.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, key_load pulse -> busy high for 10 cycles, then key_ready=1. rk_start -> round_key=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_index=10. Nine rk_next -> round_key=a0fafe1788542cb123a339392a6c7605 (index 1). One more rk_next -> round_key=2b7e1516..., last_key=1.
- Key 000102030405060708090a0b0c0d0e0f -> index 10 key = 13111d7fe3944a17f307a78b4d2b30c5; index 1 key = d6aa74fdd2af72fadaa678f1d6ab76fe.
- rk_next at index 0 -> rk_valid=0, state READY. A second rk_start replays from key 10 with identical values.
- key_load issued at expansion cycle 5, then again mid-stream with a new key -> busy restarts, key_ready and rk_valid drop the next cycle. After 10 cycles the keys match the new key's golden values.
- rst_n asserted asynchronously mid-STREAM, between clock edges -> all outputs zero immediately. rk_start after release is ignored until key_load plus 10 cycles.
- Simultaneous rk_start and rk_next at index 4 -> round_key = key 10; lone rk_next in READY -> no change.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states, forward S-box table and xtime.
package aes_pkg;
  localparam int AES_NR  = 10;
  localparam int AES_NK  = 4;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = SBOX[din];
endmodule

// File: rtl/inv_key_stream.sv
// AES-128 round-key expander feeding keys 10..0 to the inverse-round datapath.
// Expansion: 10 cycles after key_load; each request updates round_key on the next edge.
module inv_key_stream
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [BLOCK_W-1:0] cipher_key,
  input  logic               rk_start,
  input  logic               rk_next,
  output logic               key_ready,
  output logic               busy,
  output logic [BLOCK_W-1:0] round_key,
  output logic               rk_valid,
  output logic [3:0]         rk_index,
  output logic               last_key
);
  localparam logic [3:0] LAST = 4'(NR);

  ks_state_t          state, state_nxt;
  logic [3:0]         cnt, ptr, ptr_dn;
  logic [7:0]         rcon;
  logic [BLOCK_W-1:0] rk [0:NR];
  logic [BLOCK_W-1:0] prev_key, next_key;
  logic [31:0]        rot_word, sub_word, t_word;
  logic [31:0]        w0n, w1n, w2n, w3n;

  // One schedule step from the previously expanded key
  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.din(rot_word[8*g +: 8]), .dout(sub_word[8*g +: 8]));
  end

  assign t_word   = sub_word ^ {rcon, 24'h0};
  assign w0n      = prev_key[127:96] ^ t_word;
  assign w1n      = prev_key[95:64] ^ w0n;
  assign w2n      = prev_key[63:32] ^ w1n;
  assign w3n      = prev_key[31:0] ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  assign ptr_dn    = ptr - 4'd1;
  assign key_ready = (state == READY) || (state == STREAM);
  assign busy      = (state == EXPAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = EXPAND;
    end else begin
      case (state)
        EXPAND:  if (cnt == LAST) state_nxt = READY;
        READY:   if (rk_start) state_nxt = STREAM;
        STREAM:  if (!rk_start && rk_next && ptr == 4'd0) state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
      prev_key  <= '0;
      cnt       <= '0;
      rcon      <= 8'h01;
      ptr       <= '0;
      round_key <= '0;
      rk_index  <= '0;
      rk_valid  <= 1'b0;
      last_key  <= 1'b0;
    end else if (key_load) begin
      rk[0]    <= cipher_key;
      prev_key <= cipher_key;
      cnt      <= 4'd1;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
      last_key <= 1'b0;
    end else begin
      case (state)
        EXPAND: begin
          rk[cnt]  <= next_key;
          prev_key <= next_key;
          rcon     <= xtime(rcon);
          cnt      <= cnt + 4'd1;
        end
        READY, STREAM: begin
          // rk_start outranks rk_next; rk_next only matters mid-stream
          if (rk_start) begin
            ptr       <= LAST;
            round_key <= rk[LAST];
            rk_index  <= LAST;
            rk_valid  <= 1'b1;
            last_key  <= 1'b0;
          end else if (rk_next && state == STREAM) begin
            if (ptr != 4'd0) begin
              ptr       <= ptr_dn;
              round_key <= rk[ptr_dn];
              rk_index  <= ptr_dn;
              last_key  <= (ptr_dn == 4'd0);
            end else begin
              rk_valid <= 1'b0;
              last_key <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
